sparc_exu_reg_wrq: RTL and testbench

// - Write-side controller for the 4-thread per-thread register storage: merges W-stage pipeline

---
 rtl/sparc_exu_reg_wrq.sv | 128 ++++++++++++
 tb/tb_sparc_exu_reg_wrq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sparc_exu_reg_wrq.sv
// sparc_exu_reg_wrq: write-port arbiter for the 4-thread register storage.
// W-stage pipe writes always win the port; late results are parked in a
// one-entry-per-thread buffer and drained round-robin in idle write cycles.
// Pending values are forwarded to the read side combinationally.
// Optional feature macro: EXU_WRQ_DROP_CNT_EN adds drop_cnt, a saturating
// count of late results discarded because a younger pipe write superseded them.
module sparc_exu_reg_wrq #(
  parameter int SIZE = 3
) (
  input  logic            clk,
  input  logic            arst_l,
  input  logic            pipe_wen_w,
  input  logic [1:0]      pipe_tid_w,
  input  logic [SIZE-1:0] pipe_data_w,
  input  logic            late_vld,
  input  logic [1:0]      late_tid,
  input  logic [SIZE-1:0] late_data,
  output logic            late_rdy,
  input  logic [3:0]      rd_thr_out,
  output logic            wen_w,
  output logic [3:0]      thr_w,
  output logic [SIZE-1:0] data_in_w,
  output logic [3:0]      pend,
  output logic            rd_bypass_vld,
  output logic [SIZE-1:0] rd_bypass_data
`ifdef EXU_WRQ_DROP_CNT_EN
  ,
  output logic [7:0]      drop_cnt
`endif
);

  logic [3:0]      r_pend;
  logic [SIZE-1:0] r_buf [4];
  logic [1:0]      r_rr_last;

  logic            w_late_acc;
  logic            w_any_pend;
  logic            w_drain;
  logic [1:0]      w_drain_tid;
  logic [3:0]      w_pend_nxt;
  logic            w_supersede;

  assign pend       = r_pend;
  assign late_rdy   = ~r_pend[late_tid];
  assign w_late_acc = late_vld & late_rdy;
  assign w_any_pend = |r_pend;
  assign w_drain    = ~pipe_wen_w & w_any_pend;

  // a late result is always older than a pipe write to the same thread
  assign w_supersede = pipe_wen_w &
                       (r_pend[pipe_tid_w] | (w_late_acc & (late_tid == pipe_tid_w)));

  // round-robin pick: scan from farthest to nearest so the nearest pending thread after rr_last wins
  always_comb begin
    logic [1:0] v_idx;
    w_drain_tid = r_rr_last;
    v_idx       = r_rr_last;
    for (int k = 4; k >= 1; k--) begin
      v_idx = r_rr_last + 2'(k);
      if (r_pend[v_idx]) w_drain_tid = v_idx;
    end
  end

  // next pending mask: drain clears, accept sets, a pipe write to the same thread wins over both
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_drain)    w_pend_nxt[w_drain_tid] = 1'b0;
    if (w_late_acc) w_pend_nxt[late_tid]    = 1'b1;
    if (pipe_wen_w) w_pend_nxt[pipe_tid_w]  = 1'b0;
  end

  // read-side forwarding of values not yet written to storage
  always_comb begin
    rd_bypass_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (rd_thr_out[i] & r_pend[i]) rd_bypass_data = rd_bypass_data | r_buf[i];
    end
  end
  assign rd_bypass_vld = |(r_pend & rd_thr_out);

  // pending state and late-result buffers
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      r_pend <= '0;
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_late_acc) r_buf[late_tid] <= late_data;
    end
  end

  // registered storage write port and round-robin pointer
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      wen_w     <= 1'b0;
      thr_w     <= '0;
      data_in_w <= '0;
      r_rr_last <= 2'd3;
    end else if (pipe_wen_w) begin
      wen_w     <= 1'b1;
      thr_w     <= 4'b0001 << pipe_tid_w;
      data_in_w <= pipe_data_w;
    end else if (w_drain) begin
      wen_w     <= 1'b1;
      thr_w     <= 4'b0001 << w_drain_tid;
      data_in_w <= r_buf[w_drain_tid];
      r_rr_last <= w_drain_tid;
    end else begin
      wen_w <= 1'b0;
      thr_w <= '0;
    end
  end

`ifdef EXU_WRQ_DROP_CNT_EN
  // saturating count of superseded late writes
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      drop_cnt <= '0;
    end else if (w_supersede && (drop_cnt != 8'hff)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  logic w_unused_supersede;
  assign w_unused_supersede = w_supersede;
`endif

endmodule

// File: tb/tb_sparc_exu_reg_wrq.sv
// Directed bench for sparc_exu_reg_wrq: a vector table of single-cycle
// transactions plus hand-written round-robin, reset and drop-count sequences.
module tb_sparc_exu_reg_wrq;

  logic       clk = 1'b0;
  logic       arst_l;
  logic       pipe_wen_w;
  logic [1:0] pipe_tid_w;
  logic [2:0] pipe_data_w;
  logic       late_vld;
  logic [1:0] late_tid;
  logic [2:0] late_data;
  logic       late_rdy;
  logic [3:0] rd_thr_out;
  logic       wen_w;
  logic [3:0] thr_w;
  logic [2:0] data_in_w;
  logic [3:0] pend;
  logic       rd_bypass_vld;
  logic [2:0] rd_bypass_data;
`ifdef EXU_WRQ_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sparc_exu_reg_wrq #(.SIZE(3)) dut (
    .clk           (clk),
    .arst_l        (arst_l),
    .pipe_wen_w    (pipe_wen_w),
    .pipe_tid_w    (pipe_tid_w),
    .pipe_data_w   (pipe_data_w),
    .late_vld      (late_vld),
    .late_tid      (late_tid),
    .late_data     (late_data),
    .late_rdy      (late_rdy),
    .rd_thr_out    (rd_thr_out),
    .wen_w         (wen_w),
    .thr_w         (thr_w),
    .data_in_w     (data_in_w),
    .pend          (pend),
    .rd_bypass_vld (rd_bypass_vld),
    .rd_bypass_data(rd_bypass_data)
`ifdef EXU_WRQ_DROP_CNT_EN
    ,
    .drop_cnt      (drop_cnt)
`endif
  );

  typedef struct {
    logic       pw;  logic [1:0] pt; logic [2:0] pd;
    logic       lv;  logic [1:0] lt; logic [2:0] ld;
    logic [3:0] rt;
    logic       e_wen; logic [3:0] e_thr; logic [2:0] e_dat; logic [3:0] e_pend;
    logic       e_rdy; logic e_bvld; logic [2:0] e_bdat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic pw, input logic [1:0] pt, input logic [2:0] pd,
                     input logic lv, input logic [1:0] lt, input logic [2:0] ld,
                     input logic [3:0] rt,
                     input logic e_wen, input logic [3:0] e_thr, input logic [2:0] e_dat,
                     input logic [3:0] e_pend, input logic e_rdy, input logic e_bvld,
                     input logic [2:0] e_bdat);
    vec_t v;
    v.pw = pw; v.pt = pt; v.pd = pd; v.lv = lv; v.lt = lt; v.ld = ld; v.rt = rt;
    v.e_wen = e_wen; v.e_thr = e_thr; v.e_dat = e_dat; v.e_pend = e_pend;
    v.e_rdy = e_rdy; v.e_bvld = e_bvld; v.e_bdat = e_bdat;
    vecs.push_back(v);
  endtask

  // drive at negedge, return 1ns after the following rising edge
  task automatic step(input logic pw, input logic [1:0] pt, input logic [2:0] pd,
                      input logic lv, input logic [1:0] lt, input logic [2:0] ld,
                      input logic [3:0] rt);
    @(negedge clk);
    pipe_wen_w = pw; pipe_tid_w = pt; pipe_data_w = pd;
    late_vld = lv; late_tid = lt; late_data = ld; rd_thr_out = rt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_l = 1'b0;
    pipe_wen_w = 1'b0; pipe_tid_w = 2'd0; pipe_data_w = 3'd0;
    late_vld = 1'b0; late_tid = 2'd0; late_data = 3'd0; rd_thr_out = 4'hf;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen",  {31'd0, wen_w}, 32'd0);
    chk("rst_thr",  {28'd0, thr_w}, 32'd0);
    chk("rst_data", {29'd0, data_in_w}, 32'd0);
    chk("rst_pend", {28'd0, pend}, 32'd0);
    chk("rst_rdy",  {31'd0, late_rdy}, 32'd1);
    chk("rst_bvld", {31'd0, rd_bypass_vld}, 32'd0);
    @(negedge clk);
    arst_l = 1'b1;

    //  pw pt    pd    lv lt    ld    rt       wen thr      dat   pend     rdy bvld bdat
    add(1, 2'd2, 3'h5, 0, 2'd0, 3'h0, 4'b0000, 1, 4'b0100, 3'h5, 4'b0000, 1, 0, 3'h0); // pipe
    add(0, 2'd0, 3'h0, 1, 2'd1, 3'h3, 4'b0010, 0, 4'b0000, 3'h5, 4'b0010, 0, 1, 3'h3); // late accept
    add(0, 2'd0, 3'h0, 0, 2'd1, 3'h0, 4'b0010, 1, 4'b0010, 3'h3, 4'b0000, 1, 0, 3'h0); // drain t1
    add(0, 2'd0, 3'h0, 0, 2'd1, 3'h0, 4'b0000, 0, 4'b0000, 3'h3, 4'b0000, 1, 0, 3'h0); // idle hold
    add(0, 2'd0, 3'h0, 1, 2'd2, 3'h7, 4'b0100, 0, 4'b0000, 3'h3, 4'b0100, 0, 1, 3'h7); // bypass hit
    add(1, 2'd0, 3'h2, 0, 2'd2, 3'h0, 4'b0001, 1, 4'b0001, 3'h2, 4'b0100, 0, 0, 3'h0); // pipe blocks drain
    add(0, 2'd0, 3'h0, 1, 2'd3, 3'h6, 4'b1000, 1, 4'b0100, 3'h7, 4'b1000, 0, 1, 3'h6); // accept+drain
    add(1, 2'd3, 3'h1, 0, 2'd3, 3'h0, 4'b1000, 1, 4'b1000, 3'h1, 4'b0000, 1, 0, 3'h0); // supersede
    add(0, 2'd0, 3'h0, 0, 2'd3, 3'h0, 4'b1000, 0, 4'b0000, 3'h1, 4'b0000, 1, 0, 3'h0); // 6 never written
    add(1, 2'd0, 3'h5, 1, 2'd0, 3'h4, 4'b0001, 1, 4'b0001, 3'h5, 4'b0000, 1, 0, 3'h0); // same-cycle supersede
    add(0, 2'd0, 3'h0, 0, 2'd0, 3'h0, 4'b0001, 0, 4'b0000, 3'h5, 4'b0000, 1, 0, 3'h0); // idle
    add(0, 2'd0, 3'h0, 1, 2'd1, 3'h2, 4'b0010, 0, 4'b0000, 3'h5, 4'b0010, 0, 1, 3'h2); // accept t1
    add(1, 2'd3, 3'h3, 1, 2'd1, 3'h6, 4'b0010, 1, 4'b1000, 3'h3, 4'b0010, 0, 1, 3'h2); // not ready, kept
    add(0, 2'd0, 3'h0, 0, 2'd1, 3'h0, 4'b0010, 1, 4'b0010, 3'h2, 4'b0000, 1, 0, 3'h0); // rr wrap to t1

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].pw, vecs[i].pt, vecs[i].pd, vecs[i].lv, vecs[i].lt, vecs[i].ld, vecs[i].rt);
      chk($sformatf("v%0d_wen", i),  {31'd0, wen_w}, {31'd0, vecs[i].e_wen});
      chk($sformatf("v%0d_thr", i),  {28'd0, thr_w}, {28'd0, vecs[i].e_thr});
      chk($sformatf("v%0d_data", i), {29'd0, data_in_w}, {29'd0, vecs[i].e_dat});
      chk($sformatf("v%0d_pend", i), {28'd0, pend}, {28'd0, vecs[i].e_pend});
      chk($sformatf("v%0d_rdy", i),  {31'd0, late_rdy}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_bvld", i), {31'd0, rd_bypass_vld}, {31'd0, vecs[i].e_bvld});
      chk($sformatf("v%0d_bdat", i), {29'd0, rd_bypass_data}, {29'd0, vecs[i].e_bdat});
    end

    // round-robin: fresh reset puts rr_last at 3
    @(negedge clk); arst_l = 1'b0;
    @(negedge clk); arst_l = 1'b1;
    step(1, 2'd3, 3'h5, 1, 2'd1, 3'h1, 4'b0000);
    chk("rr_fill1_thr",  {28'd0, thr_w}, 32'h8);
    chk("rr_fill1_pend", {28'd0, pend}, 32'h2);
    step(1, 2'd3, 3'h5, 1, 2'd2, 3'h2, 4'b0000);
    chk("rr_fill2_thr",  {28'd0, thr_w}, 32'h8);
    chk("rr_fill2_pend", {28'd0, pend}, 32'h6);
    step(1, 2'd0, 3'h5, 1, 2'd3, 3'h3, 4'b0000);
    chk("rr_fill3_thr",  {28'd0, thr_w}, 32'h1);
    chk("rr_fill3_pend", {28'd0, pend}, 32'he);
    step(0, 2'd0, 3'h0, 1, 2'd0, 3'h4, 4'b0000);
    chk("rr_d1_thr",  {28'd0, thr_w}, 32'h2);
    chk("rr_d1_data", {29'd0, data_in_w}, 32'h1);
    chk("rr_d1_pend", {28'd0, pend}, 32'hd);
    step(0, 2'd0, 3'h0, 0, 2'd0, 3'h0, 4'b0000);
    chk("rr_d2_thr",  {28'd0, thr_w}, 32'h4);
    chk("rr_d2_data", {29'd0, data_in_w}, 32'h2);
    chk("rr_d2_pend", {28'd0, pend}, 32'h9);
    step(0, 2'd0, 3'h0, 0, 2'd0, 3'h0, 4'b0000);
    chk("rr_d3_thr",  {28'd0, thr_w}, 32'h8);
    chk("rr_d3_data", {29'd0, data_in_w}, 32'h3);
    chk("rr_d3_pend", {28'd0, pend}, 32'h1);
    step(0, 2'd0, 3'h0, 0, 2'd0, 3'h0, 4'b0000);
    chk("rr_d4_thr",  {28'd0, thr_w}, 32'h1);
    chk("rr_d4_data", {29'd0, data_in_w}, 32'h4);
    chk("rr_d4_pend", {28'd0, pend}, 32'h0);
    step(0, 2'd0, 3'h0, 0, 2'd0, 3'h0, 4'b0000);
    chk("rr_idle_wen", {31'd0, wen_w}, 32'd0);
    chk("rr_idle_thr", {28'd0, thr_w}, 32'd0);

    // asynchronous reset in the middle of a busy cycle
    step(1, 2'd1, 3'h5, 1, 2'd0, 3'h1, 4'b0101);
    step(1, 2'd1, 3'h5, 1, 2'd2, 3'h7, 4'b0101);
    chk("ar_pre_pend", {28'd0, pend}, 32'h5);
    chk("ar_pre_wen",  {31'd0, wen_w}, 32'd1);
    late_vld = 1'b0; late_tid = 2'd0; pipe_wen_w = 1'b0;
    #1;
    chk("ar_pre_rdy", {31'd0, late_rdy}, 32'd0);
    #1;
    arst_l = 1'b0;
    #1;
    chk("ar_wen",  {31'd0, wen_w}, 32'd0);
    chk("ar_thr",  {28'd0, thr_w}, 32'd0);
    chk("ar_data", {29'd0, data_in_w}, 32'd0);
    chk("ar_pend", {28'd0, pend}, 32'd0);
    chk("ar_rdy",  {31'd0, late_rdy}, 32'd1);
    chk("ar_bvld", {31'd0, rd_bypass_vld}, 32'd0);
    chk("ar_bdat", {29'd0, rd_bypass_data}, 32'd0);
    @(negedge clk); arst_l = 1'b1;
    step(0, 2'd0, 3'h0, 0, 2'd0, 3'h0, 4'b0000);
    chk("ar_after_wen", {31'd0, wen_w}, 32'd0);

`ifdef EXU_WRQ_DROP_CNT_EN
    chk("dc_reset", {24'd0, drop_cnt}, 32'd0);
    step(0, 2'd0, 3'h0, 1, 2'd3, 3'h6, 4'b0000);
    step(1, 2'd3, 3'h1, 0, 2'd0, 3'h0, 4'b0000);
    chk("dc_one", {24'd0, drop_cnt}, 32'd1);
    for (int i = 0; i < 255; i++) step(1, 2'd0, 3'h5, 1, 2'd0, 3'h4, 4'b0000);
    chk("dc_sat", {24'd0, drop_cnt}, 32'd255);
    step(1, 2'd0, 3'h5, 1, 2'd0, 3'h4, 4'b0000);
    chk("dc_hold", {24'd0, drop_cnt}, 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
